// File: rtl/mac_accumulator.sv
// mac_accumulator: sums a programmed number of unsigned products from the multiplier and
// returns the total over valid/ready. Define MAC_ACC_SAT_EN to clamp on carry-out instead of wrapping.
module mac_accumulator #(
   parameter int PROD_W = 32,
   parameter int ACC_W  = 40,  // must be >= PROD_W
   parameter int LEN_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] product,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic              overflow,
   output logic              busy,
   output logic [1:0]        dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // a producer keeps valid and its payload steady until that edge.
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ACC  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [LEN_W-1:0] count;
   logic [ACC_W-1:0] acc;
   logic             ovf;
   logic [ACC_W:0]   sum;
   logic [ACC_W-1:0] acc_next;
   logic             beat;

   assign in_ready  = (state == ACC);
   assign out_valid = (state == DONE);
   assign busy      = (state == ACC) | (state == DONE);
   assign acc_out   = acc;
   assign overflow  = ovf;
   assign dbg_state = state;

   assign beat = in_valid & in_ready;
   assign sum  = {1'b0, acc} + (ACC_W+1)'(product);

   // Once clamped, every later sum carries again (or adds zero), so the clamp holds.
   always_comb begin
`ifdef MAC_ACC_SAT_EN
      acc_next = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
      acc_next = sum[ACC_W-1:0];
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         count <= '0;
         acc   <= '0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  acc <= '0;
                  ovf <= 1'b0;
                  if (len == '0) begin
                     count <= '0;
                     state <= DONE;
                  end else begin
                     count <= len;
                     state <= ACC;
                  end
               end
            end
            ACC: begin
               if (beat) begin
                  acc   <= acc_next;
                  ovf   <= ovf | sum[ACC_W];
                  count <= count - LEN_W'(1);
                  if (count == LEN_W'(1)) state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator at ACC_W=32: directed cases plus randomized jobs checked by a
// scoreboard fed from a sum-of-products reference model.
module tb_mac_accumulator;

   localparam int PROD_W = 32;
   localparam int ACC_W  = 32;
   localparam int LEN_W  = 8;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic [LEN_W-1:0]  len;
   logic              in_valid;
   logic              in_ready;
   logic [PROD_W-1:0] product;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  acc_out;
   logic              overflow;
   logic              busy;
   logic [1:0]        dbg_state;

   int total = 0;
   int bad   = 0;
   logic [ACC_W:0]    exp_q[$];
   logic [PROD_W-1:0] prods[256];
   bit                ready_force;

   mac_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len),
      .in_valid(in_valid), .in_ready(in_ready), .product(product),
      .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
      .overflow(overflow), .busy(busy), .dbg_state(dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // reference model: plain sum of the job's products
   function automatic logic [ACC_W:0] model_result(input int n);
      longint unsigned sum_all = 0;
      longint unsigned lim = 64'd1 << ACC_W;
      for (int i = 0; i < n; i++) sum_all += 64'(prods[i]);
      if (sum_all >= lim) begin
`ifdef MAC_ACC_SAT_EN
         return {1'b1, {ACC_W{1'b1}}};
`else
         return {1'b1, sum_all[ACC_W-1:0]};
`endif
      end
      return {1'b0, sum_all[ACC_W-1:0]};
   endfunction

   // random out_ready unless a directed test takes over
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!ready_force) out_ready = 1'($urandom_range(0, 1));
      end
   end

   // monitor: result must match the queue head every cycle it is presented
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_result acc_out=%0h overflow=%0b required=none", acc_out, overflow);
            end else begin
               check("result_acc", 64'(acc_out), 64'(exp_q[0][ACC_W-1:0]));
               check("result_ovf", 64'(overflow), 64'(exp_q[0][ACC_W]));
               if (out_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   // driver tasks; all run at 1 time unit after a rising edge
   task automatic wait_idle();
      int guard = 0;
      while (busy) begin
         start = 1'($urandom_range(0, 1));
         len   = LEN_W'($urandom_range(0, 255));
         @(posedge clk);
         #1;
         start = 1'b0;
         guard++;
         if (guard > 2000) begin
            check("wait_idle_timeout", 64'(busy), 64'd0);
            break;
         end
      end
   endtask

   task automatic start_job(input int n);
      wait_idle();
      exp_q.push_back(model_result(n));
      start = 1'b1;
      len   = LEN_W'(n);
      @(posedge clk);
      #1;
      start = 1'b0;
      len   = LEN_W'($urandom_range(0, 255));
   endtask

   // gap < 0 selects random idle cycles between beats, with stray start pulses
   task automatic feed(input int n, input int gap);
      int g;
      for (int i = 0; i < n; i++) begin
         int guard = 0;
         in_valid = 1'b1;
         product  = prods[i];
         while (!in_ready) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 100) begin
               check("in_ready_timeout", 64'(in_ready), 64'd1);
               break;
            end
         end
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         product  = $urandom;
         if (i < n - 1) begin
            g = (gap < 0) ? $urandom_range(0, 3) : gap;
            repeat (g) begin
               if (gap < 0) begin
                  start = 1'($urandom_range(0, 1));
                  len   = LEN_W'($urandom_range(0, 255));
               end
               @(posedge clk);
               #1;
               start = 1'b0;
            end
         end
      end
   endtask

   task automatic check_all_zero(input string nm);
      check({nm, "_acc"}, 64'(acc_out), 64'd0);
      check({nm, "_ovf"}, 64'(overflow), 64'd0);
      check({nm, "_in_ready"}, 64'(in_ready), 64'd0);
      check({nm, "_out_valid"}, 64'(out_valid), 64'd0);
      check({nm, "_busy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; product = '0;
      ready_force = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // three consecutive beats, consumer always ready
      out_ready = 1'b1;
      prods[0] = 6; prods[1] = 20; prods[2] = 100;
      start_job(3);
      feed(3, 0);
      check("lat_out_valid", 64'(out_valid), 64'd1);
      check("lat_acc", 64'(acc_out), 64'd126);
      @(posedge clk);
      #1;
      check("back_idle_busy", 64'(busy), 64'd0);
      check("back_idle_valid", 64'(out_valid), 64'd0);

      // gapped input, consumer stalls for four cycles
      out_ready = 1'b0;
      prods[0] = 5; prods[1] = 7;
      start_job(2);
      feed(2, 3);
      repeat (4) begin
         check("stall_out_valid", 64'(out_valid), 64'd1);
         check("stall_in_ready", 64'(in_ready), 64'd0);
         check("stall_acc", 64'(acc_out), 64'd12);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("stall_release_busy", 64'(busy), 64'd0);

      // zero-length job
      start_job(0);
      in_valid = 1'b1;
      check("len0_out_valid", 64'(out_valid), 64'd1);
      check("len0_in_ready", 64'(in_ready), 64'd0);
      check("len0_acc", 64'(acc_out), 64'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;

      // carry out of the accumulator
      prods[0] = 32'hFFFF_FFFF; prods[1] = 32'h0000_0002;
      start_job(2);
      feed(2, 0);
      check("carry_ovf", 64'(overflow), 64'd1);
      @(posedge clk);
      #1;

      // asynchronous reset in the middle of a job
      for (int i = 0; i < 4; i++) prods[i] = $urandom;
      start_job(4);
      feed(2, 0);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check_all_zero("async_reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      prods[0] = 9;
      start_job(1);
      feed(1, 0);
      check("after_reset_acc", 64'(acc_out), 64'd9);
      check("after_reset_ovf", 64'(overflow), 64'd0);

      // randomized jobs with random backpressure and stray start pulses
      ready_force = 1'b0;
      for (int j = 0; j < 40; j++) begin
         int n = (j == 20) ? 255 : $urandom_range(0, 10);
         bit big = 1'($urandom_range(0, 1));
         for (int i = 0; i < n; i++) prods[i] = big ? $urandom : PROD_W'($urandom_range(0, 1000));
         start_job(n);
         feed(n, -1);
      end

      ready_force = 1'b1;
      out_ready = 1'b1;
      wait_idle();
      repeat (3) @(posedge clk);
      #1;
      check("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
